// File: rtl/pipefetch_if.sv
// Instruction-memory req/ack bus between the fetch stage and instruction memory.
// A transfer completes in any cycle where req && ack; rdata is valid only with ack.
interface pipefetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/pipefetch.sv
// IF stage controller: drives PC write enable, imem req/ack and the IF/ID register (optional PIPEFETCH_PERF_EN counters).
// Latency: instruction acked at edge N is visible on inst after edge N; each ack-wait cycle inserts one bubble.
// Backpressure: id_stall holds IF/ID, parking an acked word in a one-entry hold buffer; flush overrides everything.
module pipefetch #(
  parameter logic [31:0] NOP = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] pc,
  output logic        pc_we,
  pipefetch_if.master imem,
  input  logic        id_stall,
  input  logic        flush,
  output logic [31:0] inst,
  output logic [31:0] dpc4,
  output logic        inst_valid
`ifdef PIPEFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_stalls,
  output logic [31:0] perf_flushes
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] hold_inst, hold_pc4, drop_addr;
  logic [31:0] pc4;
  logic        ack;
  logic        ld_mem, ld_buf, ld_nop, buf_we, drop_we;

  assign pc4 = pc + 32'd4;
  assign ack = imem.ack;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_we     = 1'b0;
    imem.req  = 1'b0;
    imem.addr = pc;
    ld_mem    = 1'b0;
    ld_buf    = 1'b0;
    ld_nop    = 1'b0;
    buf_we    = 1'b0;
    drop_we   = 1'b0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        imem.req = 1'b1;
        if (flush) begin
          pc_we  = 1'b1;
          ld_nop = 1'b1;
          if (!ack) begin
            drop_we   = 1'b1;
            state_nxt = DROP;
          end
        end else if (id_stall) begin
          if (ack) begin
            buf_we    = 1'b1;
            pc_we     = 1'b1;
            state_nxt = HOLD;
          end
        end else if (ack) begin
          ld_mem = 1'b1;
          pc_we  = 1'b1;
        end else begin
          ld_nop = 1'b1;
        end
      end
      HOLD: begin
        if (flush) begin
          pc_we     = 1'b1;
          ld_nop    = 1'b1;
          state_nxt = FETCH;
        end else if (!id_stall) begin
          ld_buf    = 1'b1;
          state_nxt = FETCH;
        end
      end
      DROP: begin
        // Keep the abandoned request alive at its original address until memory acks it.
        imem.req  = 1'b1;
        imem.addr = drop_addr;
        pc_we     = flush;
        if (ack) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      inst       <= NOP;
      dpc4       <= 32'd0;
      inst_valid <= 1'b0;
    end else if (ld_nop) begin
      inst       <= NOP;
      inst_valid <= 1'b0;
    end else if (ld_mem) begin
      inst       <= imem.rdata;
      dpc4       <= pc4;
      inst_valid <= 1'b1;
    end else if (ld_buf) begin
      inst       <= hold_inst;
      dpc4       <= hold_pc4;
      inst_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      hold_inst <= 32'd0;
      hold_pc4  <= 32'd0;
      drop_addr <= 32'd0;
    end else begin
      if (buf_we) begin
        hold_inst <= imem.rdata;
        hold_pc4  <= pc4;
      end
      if (drop_we) drop_addr <= pc;
    end
  end

`ifdef PIPEFETCH_PERF_EN
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      perf_fetches <= 32'd0;
      perf_stalls  <= 32'd0;
      perf_flushes <= 32'd0;
    end else begin
      if (state == FETCH && ack && !flush) perf_fetches <= perf_fetches + 32'd1;
      if (id_stall) perf_stalls  <= perf_stalls + 32'd1;
      if (flush)    perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipefetch.sv
// Directed vector bench for pipefetch: table of per-cycle inputs with hand-computed outputs,
// plus an asynchronous reset issued mid-request.
module tb_pipefetch;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] pc;
  logic        pc_we;
  logic        id_stall;
  logic        flush;
  logic [31:0] inst;
  logic [31:0] dpc4;
  logic        inst_valid;
`ifdef PIPEFETCH_PERF_EN
  logic [31:0] perf_fetches, perf_stalls, perf_flushes;
`endif

  pipefetch_if imem ();

  pipefetch #(.NOP(32'h0000_0000)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .pc         (pc),
    .pc_we      (pc_we),
    .imem       (imem.master),
    .id_stall   (id_stall),
    .flush      (flush),
    .inst       (inst),
    .dpc4       (dpc4),
    .inst_valid (inst_valid)
`ifdef PIPEFETCH_PERF_EN
    ,
    .perf_fetches (perf_fetches),
    .perf_stalls  (perf_stalls),
    .perf_flushes (perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        stall;
    logic        flsh;
    logic [31:0] tgt;
    logic        e_we;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_inst;
    logic        e_vld;
    logic [31:0] e_dpc4;
    logic        c_dpc4;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic a, input logic [31:0] rd, input logic st, input logic fl,
                     input logic [31:0] tg, input logic we, input logic rq, input logic [31:0] ad,
                     input logic [31:0] in, input logic vl, input logic [31:0] d4, input logic cd);
    vec_t v;
    v.ack = a; v.rdata = rd; v.stall = st; v.flsh = fl; v.tgt = tg;
    v.e_we = we; v.e_req = rq; v.e_addr = ad; v.e_inst = in; v.e_vld = vl;
    v.e_dpc4 = d4; v.c_dpc4 = cd;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %h, want %h", name, idx, act, exp);
    end
  endtask

  initial begin
    clrn = 1'b0; pc = 32'd0; id_stall = 1'b0; flush = 1'b0;
    imem.ack = 1'b0; imem.rdata = 32'd0;

    //   ack rdata          st fl tgt            we rq addr          inst          v  dpc4 cd
    add(0, 32'h0,          0, 0, 32'h0,         0, 0, 32'h0,        32'h0,        0, 32'h0,   1); // IDLE
    add(1, 32'h100,        0, 0, 32'h0,         1, 1, 32'h0,        32'h100,      1, 32'h4,   1);
    add(1, 32'h104,        0, 0, 32'h0,         1, 1, 32'h4,        32'h104,      1, 32'h8,   1);
    add(1, 32'h108,        0, 0, 32'h0,         1, 1, 32'h8,        32'h108,      1, 32'hC,   1);
    add(1, 32'h10C,        0, 0, 32'h0,         1, 1, 32'hC,        32'h10C,      1, 32'h10,  1);
    add(1, 32'hAAAA,       1, 0, 32'h0,         1, 1, 32'h10,       32'h10C,      1, 32'h10,  1); // ack under stall
    add(0, 32'h0,          1, 0, 32'h0,         0, 0, 32'h14,       32'h10C,      1, 32'h10,  1);
    add(0, 32'h0,          0, 0, 32'h0,         0, 0, 32'h14,       32'hAAAA,     1, 32'h14,  1);
    add(1, 32'h55,         0, 1, 32'h40,        1, 1, 32'h14,       32'h0,        0, 32'h0,   0); // flush with ack
    add(0, 32'h0,          0, 0, 32'h0,         0, 1, 32'h40,       32'h0,        0, 32'h0,   0);
    add(0, 32'h0,          0, 0, 32'h0,         0, 1, 32'h40,       32'h0,        0, 32'h0,   0);
    add(1, 32'hDEAD0001,   0, 0, 32'h0,         1, 1, 32'h40,       32'hDEAD0001, 1, 32'h44,  1);
    add(0, 32'h0,          0, 1, 32'h20,        1, 1, 32'h44,       32'h0,        0, 32'h0,   0); // -> DROP
    add(1, 32'hBAD0,       0, 0, 32'h0,         0, 1, 32'h44,       32'h0,        0, 32'h0,   0);
    add(0, 32'h0,          0, 1, 32'h80,        1, 1, 32'h20,       32'h0,        0, 32'h0,   0); // -> DROP @0x20
    add(0, 32'h0,          0, 0, 32'h0,         0, 1, 32'h20,       32'h0,        0, 32'h0,   0);
    add(0, 32'h0,          1, 0, 32'h0,         0, 1, 32'h20,       32'h0,        0, 32'h0,   0);
    add(1, 32'hBAD,        0, 0, 32'h0,         0, 1, 32'h20,       32'h0,        0, 32'h0,   0);
    add(1, 32'h1234,       0, 0, 32'h0,         1, 1, 32'h80,       32'h1234,     1, 32'h84,  1);
    add(0, 32'h0,          0, 1, 32'h90,        1, 1, 32'h84,       32'h0,        0, 32'h0,   0); // -> DROP
    add(0, 32'h0,          0, 1, 32'hA0,        1, 1, 32'h84,       32'h0,        0, 32'h0,   0); // flush in DROP
    add(1, 32'hBAD,        0, 0, 32'h0,         0, 1, 32'h84,       32'h0,        0, 32'h0,   0);
    add(1, 32'h77,         0, 0, 32'h0,         1, 1, 32'hA0,       32'h77,       1, 32'hA4,  1);
    add(1, 32'h99,         1, 0, 32'h0,         1, 1, 32'hA4,       32'h77,       1, 32'hA4,  1); // -> HOLD
    add(0, 32'h0,          1, 1, 32'h200,       1, 0, 32'hA8,       32'h0,        0, 32'h0,   0); // flush+stall in HOLD
    add(1, 32'h300,        0, 0, 32'h0,         1, 1, 32'h200,      32'h300,      1, 32'h204, 1);
    add(0, 32'h0,          1, 0, 32'h0,         0, 1, 32'h204,      32'h300,      1, 32'h204, 1);
    add(0, 32'h0,          0, 0, 32'h0,         0, 1, 32'h204,      32'h0,        0, 32'h0,   0);
    add(1, 32'h1,          0, 1, 32'hFFFFFFFC,  1, 1, 32'h204,      32'h0,        0, 32'h0,   0);
    add(1, 32'hC0DE,       0, 0, 32'h0,         1, 1, 32'hFFFFFFFC, 32'hC0DE,     1, 32'h0,   1); // dpc4 wraps
    add(1, 32'h2,          1, 1, 32'h10,        1, 1, 32'h0,        32'h0,        0, 32'h0,   0); // flush beats stall
    add(1, 32'h5,          0, 0, 32'h0,         1, 1, 32'h10,       32'h5,        1, 32'h14,  1);

    #12;
    n_vec++;
    chk("rst_req",   -1, {31'd0, imem.req},   32'd0);
    chk("rst_pc_we", -1, {31'd0, pc_we},      32'd0);
    chk("rst_inst",  -1, inst,                32'd0);
    chk("rst_dpc4",  -1, dpc4,                32'd0);
    chk("rst_vld",   -1, {31'd0, inst_valid}, 32'd0);
    chk("rst_addr",  -1, imem.addr,           pc);

    @(posedge clk); #1;
    clrn = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      imem.ack = vq[i].ack; imem.rdata = vq[i].rdata;
      id_stall = vq[i].stall; flush = vq[i].flsh;
      #1;
      n_vec++;
      chk("pc_we", i, {31'd0, pc_we},    {31'd0, vq[i].e_we});
      chk("req",   i, {31'd0, imem.req}, {31'd0, vq[i].e_req});
      chk("addr",  i, imem.addr,         vq[i].e_addr);
      @(posedge clk); #1;
      chk("inst",  i, inst,                vq[i].e_inst);
      chk("valid", i, {31'd0, inst_valid}, {31'd0, vq[i].e_vld});
      if (vq[i].c_dpc4) chk("dpc4", i, dpc4, vq[i].e_dpc4);
      if (vq[i].e_we) pc = vq[i].flsh ? vq[i].tgt : pc + 32'd4;
    end

    // Asynchronous reset while a request is outstanding (pc = 0x14, state FETCH).
    imem.ack = 1'b0; id_stall = 1'b0; flush = 1'b0;
    #1;
    n_vec++;
    chk("mid_req_pre", 100, {31'd0, imem.req}, 32'd1);
    #2 clrn = 1'b0;
    #1;
    chk("mid_req",   100, {31'd0, imem.req},   32'd0);
    chk("mid_pc_we", 100, {31'd0, pc_we},      32'd0);
    chk("mid_inst",  100, inst,                32'd0);
    chk("mid_vld",   100, {31'd0, inst_valid}, 32'd0);
    chk("mid_dpc4",  100, dpc4,                32'd0);
    chk("mid_addr",  100, imem.addr,           32'h14);
    @(posedge clk); #1;
    clrn = 1'b1;
    #1;
    n_vec++;
    chk("post_idle_req", 101, {31'd0, imem.req}, 32'd0);
    @(posedge clk); #1;
    n_vec++;
    chk("post_fetch_req",  102, {31'd0, imem.req}, 32'd1);
    chk("post_fetch_addr", 102, imem.addr,         32'h14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
